// File: rtl/uart_program_loader.sv
// UART program loader: packs received bytes MSB-first into 32-bit words and stores them in program memory.
// Optional partial-word idle timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_program_loader #(
  parameter int unsigned MEM_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_data_valid,
  input  logic [7:0]  io_data_packet,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        word_valid,
  output logic [31:0] instruction_word,
  output logic [31:0] byte_address
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] shifted;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign shifted = {asm_q[23:0], io_data_packet};
  assign wr_idx  = addr_q[AW+1:2];
  assign rd_idx  = read_address[AW+1:2];

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_address[31:AW+2], read_address[1:0]};

  // Next-state logic: byte assembly, word completion and address advance
  always_comb begin
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    word_valid_d = 1'b0;
    instr_d      = instr_q;
    addr_d       = addr_q;
`ifdef UART_LOADER_TIMEOUT_EN
    idle_d       = idle_q;
`endif

    if (io_data_valid) begin
      asm_d = shifted;
      if (cnt_q == 2'd3) begin
        cnt_d        = 2'd0;
        word_valid_d = 1'b1;
        instr_d      = shifted;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end

    // Index wraps naturally at MEM_WORDS, so the byte address wraps with it
    if (word_valid_q) begin
      addr_d = 32'({wr_idx + AW'(1), 2'b00});
    end

`ifdef UART_LOADER_TIMEOUT_EN
    // Discard a stalled partial word; the write address is left alone
    if (io_data_valid || (cnt_q == 2'd0)) begin
      idle_d = '0;
    end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
      idle_d = '0;
      cnt_d  = 2'd0;
      asm_d  = 32'd0;
    end else begin
      idle_d = idle_q + IW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= 2'd0;
      asm_q        <= 32'd0;
      word_valid_q <= 1'b0;
      instr_q      <= 32'd0;
      addr_q       <= 32'd0;
`ifdef UART_LOADER_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      word_valid_q <= word_valid_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
`ifdef UART_LOADER_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  // Program memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (word_valid_q) begin
      mem_q[wr_idx] <= instr_q;
    end
  end

  assign read_data        = mem_q[rd_idx];
  assign word_valid       = word_valid_q;
  assign instruction_word = instr_q;
  assign byte_address     = addr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader (MEM_WORDS=4, TIMEOUT_CYCLES=16).
module tb_uart_program_loader;

  logic        clk;
  logic        reset_n;
  logic        io_data_valid;
  logic [7:0]  io_data_packet;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        word_valid;
  logic [31:0] instruction_word;
  logic [31:0] byte_address;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [63:0] exp_q [$];

  uart_program_loader #(.MEM_WORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .io_data_valid    (io_data_valid),
    .io_data_packet   (io_data_packet),
    .read_address     (read_address),
    .read_data        (read_data),
    .word_valid       (word_valid),
    .instruction_word (instruction_word),
    .byte_address     (byte_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every word_valid cycle
  always @(negedge clk) begin
    if (reset_n && word_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_word_valid", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("instruction_word", instruction_word, e[63:32]);
        check("byte_address", byte_address, e[31:0]);
      end
    end
  end

  task automatic expect_word(input logic [31:0] w, input logic [31:0] a);
    exp_q.push_back({w, a});
  endtask

  // Called at a negedge; returns at the following negedge with strobe dropped
  task automatic send_byte(input logic [7:0] b, input int gap);
    io_data_valid  = 1'b1;
    io_data_packet = b;
    @(negedge clk);
    io_data_valid  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    read_address = a;
    #1;
    check(name, read_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n        = 1'b0;
    io_data_valid  = 1'b0;
    io_data_packet = 8'h00;
    read_address   = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_word_valid", 32'(word_valid), 32'd0);
    check("reset_instruction_word", instruction_word, 32'd0);
    check("reset_byte_address", byte_address, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Idle period: no pulses, address stays put
    repeat (100) @(negedge clk);
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_byte_address", byte_address, 32'd0);

    // Two-word load with spaced strobes
    p0 = pulses;
    expect_word(32'h00400093, 32'd0);
    send_word(32'h00400093, 3);
    expect_word(32'h00800113, 32'd4);
    send_word(32'h00800113, 3);
    repeat (3) @(negedge clk);
    check("two_word_pulses", 32'(pulses - p0), 32'd2);
    check("two_word_addr_after", byte_address, 32'd8);
    check_read("rd_addr0", 32'd0, 32'h00400093);
    check_read("rd_addr4", 32'd4, 32'h00800113);
    check_read("rd_addr6", 32'd6, 32'h00800113);
    @(negedge clk);

    // Back-to-back bytes
    do_reset();
    p0 = pulses;
    expect_word(32'h11223344, 32'd0);
    expect_word(32'h55667788, 32'd4);
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 0);
    repeat (3) @(negedge clk);
    check("b2b_pulses", 32'(pulses - p0), 32'd2);
    check_read("b2b_mem0", 32'd0, 32'h11223344);
    check_read("b2b_mem1", 32'd4, 32'h55667788);
    @(negedge clk);

    // Reset mid-word discards AA BB
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    check("midreset_byte_address", byte_address, 32'd0);
    expect_word(32'hDEADBEEF, 32'd0);
    send_word(32'hDEADBEEF, 1);
    repeat (3) @(negedge clk);
    check_read("midreset_mem0", 32'd0, 32'hDEADBEEF);
    check("midreset_addr_after", byte_address, 32'd4);
    @(negedge clk);

    // Wrap-around across 4-word memory
    do_reset();
    expect_word(32'hA0000000, 32'd0);
    expect_word(32'hA1111111, 32'd4);
    expect_word(32'hA2222222, 32'd8);
    expect_word(32'hA3333333, 32'd12);
    expect_word(32'hA4444444, 32'd0);
    send_word(32'hA0000000, 0);
    send_word(32'hA1111111, 0);
    send_word(32'hA2222222, 0);
    send_word(32'hA3333333, 0);
    send_word(32'hA4444444, 0);
    repeat (3) @(negedge clk);
    check_read("wrap_mem0", 32'd0, 32'hA4444444);
    check_read("wrap_mem1", 32'd4, 32'hA1111111);
    check_read("wrap_mem2", 32'd8, 32'hA2222222);
    check_read("wrap_mem3", 32'd12, 32'hA3333333);
    check_read("wrap_alias", 32'h0000_0104, 32'hA1111111);
    @(negedge clk);

    // Partial word then long idle
    do_reset();
`ifdef UART_LOADER_TIMEOUT_EN
    expect_word(32'h0A0B0C0D, 32'd0);
`else
    expect_word(32'h01020A0B, 32'd0);
`endif
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    repeat (20) @(negedge clk);
    send_byte(8'h0A, 0);
    send_byte(8'h0B, 0);
    send_byte(8'h0C, 0);
    send_byte(8'h0D, 0);
    repeat (3) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
    check_read("timeout_mem0", 32'd0, 32'h0A0B0C0D);
`else
    check_read("timeout_mem0", 32'd0, 32'h01020A0B);
`endif
    @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
